ama_riscv_fetch: RTL and testbench
==================================

Name: ama_riscv_fetch

Overview:
- Instruction-fetch (IF) stage. Sits directly upstream of the decoder.
- Owns the fetch PC and issues in-order requests to IMEM over a valid/ready interface.
- Buffers returned words in a small fetch queue and drives the IF/ID pipeline register (inst_id, pc_id) that the decoder consumes.
- Obeys the decoder's pc_sel/pc_we/stall_if/clear_id controls, including redirect flush with discard of in-flight responses.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset or a START_ADDR select.
- FQ_DEPTH, 2, fetch-queue entries; also the cap on queued plus outstanding requests (≥1).
- NOP_INST, 32'h0000_0013, bubble injected into ID (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pc_sel  in  2  decoder PC select: PC_SEL_START_ADDR / PC_SEL_INC4 / PC_SEL_ALU; any other code is treated as INC4.
- pc_we  in  1  decoder PC write enable; gates redirects.
- stall_if  in  1  decoder stall; ID receives a bubble and the queue does not pop.
- clear_id  in  1  forces the ID register to NOP.
- alu_out  in  32  redirect target from EX.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address.
- imem_ready  in  1  IMEM accepts the request this cycle.
- imem_rsp_valid  in  1  in-order response valid.
- imem_rsp_data  in  32  instruction word.
- inst_id  out  32  instruction to decoder.
- pc_id  out  32  PC of inst_id.
- inst_valid_id  out  1  inst_id is a real instruction, not a bubble.
- fetch_misalign  out  1  one-cycle pulse: redirect target had alu_out[1]=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_VECTOR.
  - Queue empty; outstanding=0; drop_cnt=0.
  - imem_req=0, inst_id=NOP_INST, pc_id=RESET_VECTOR, inst_valid_id=0, fetch_misalign=0.
  - The first imem_req can assert in the cycle after rst deasserts.
- Credit rule:
  - imem_req=1 iff (q_count + outstanding) < FQ_DEPTH and no flush this cycle.
  - imem_addr=fetch_pc.
  - On accept (imem_req && imem_ready): fetch_pc += 4 (32-bit wrap), outstanding++.
  - imem_req may drop without an accept, since the source is non-committal.
- Response handling:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: discard the word, drop_cnt--.
  - Otherwise push {imem_rsp_data, pc_of_request}. Request PCs are tracked in a FQ_DEPTH-entry PC FIFO written on accept.
- Flush (highest priority):
  - START: pc_sel==PC_SEL_START_ADDR → fetch_pc=RESET_VECTOR.
  - Redirect: pc_we && pc_sel==PC_SEL_ALU → fetch_pc={alu_out[31:2],2'b00}; fetch_misalign=alu_out[1] for one cycle.
  - Either flush:
    - Empties the queue.
    - Sets drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0); a same-cycle response is itself discarded.
    - Forces imem_req=0 that cycle.
    - The first request to the new PC is issued the next cycle.
- ID register (updated every cycle):
  - Priority: clear_id or flush → NOP, valid=0.
  - Else stall_if → NOP, valid=0, no pop.
  - Else queue non-empty → head popped into inst_id/pc_id, valid=1.
  - Else NOP, valid=0.
  - pc_id holds its last value when a bubble is loaded.
- Bypass: a response arriving while the queue is empty and a pop is permitted reaches inst_id at the next edge; one cycle from rsp_valid to inst_id, no extra queue cycle.
- Full queue: push and pop in the same cycle are both legal. A push while full with no pop is impossible by the credit rule; assert in simulation.
- Counter widths: $clog2(FQ_DEPTH+1). outstanding never exceeds FQ_DEPTH; drop_cnt ≤ outstanding always.
- Reset mid-operation clears everything immediately. Responses arriving after reset for pre-reset requests are the IMEM's responsibility (IMEM is reset with the core).

Test Plan:
- Reset release, imem_ready=1, 1-cycle-latency IMEM returning addr^32'hA5A5_0000 → imem_addr sequence 0,4,8,…; inst_id = 32'hA5A5_0000, 32'hA5A5_0004, … in consecutive cycles; inst_valid_id=1 after two cycles.
- imem_ready=0 for 5 cycles mid-stream at addr 0x10 → imem_addr held at 0x10, inst_valid_id=0 bubbles; no address skipped when ready returns.
- stall_if=1 for 2 cycles with 2 words queued → inst_id=NOP_INST twice, no pop; then the queued words at pc 0x8 and 0xC appear in order.
- Redirect pc_we=1, pc_sel=ALU, alu_out=0x200 with 2 requests outstanding → both late responses discarded; next imem_addr=0x200; next valid inst_id has pc_id=0x200.
- Redirect with alu_out=0x0000_0102 → imem_addr=0x100, fetch_misalign pulses 1 cycle.
- Redirect coincident with imem_rsp_valid and clear_id=1 → that response dropped, drop_cnt = outstanding−1, inst_id=NOP_INST; then START select → imem_addr=RESET_VECTOR.

Source files
------------

// File: rtl/ama_riscv_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited IMEM requests,
// buffers in-order responses in a small queue and drives the IF/ID register.
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH     = 2,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic        pc_we,
  input  logic        stall_if,
  input  logic        clear_id,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        inst_valid_id,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    PC_SEL_START_ADDR = 2'd0,
    PC_SEL_INC4       = 2'd1,
    PC_SEL_ALU        = 2'd2
  } pc_sel_e;

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FQ_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FQ_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fq_cnt_q, fq_cnt_d;
  logic [PW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [31:0]   fq_inst_q [FQ_DEPTH];
  logic [31:0]   fq_inst_d [FQ_DEPTH];
  logic [31:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_pc_d   [FQ_DEPTH];
  logic [PW-1:0] pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
  logic [31:0]   pcf_q [FQ_DEPTH];
  logic [31:0]   pcf_d [FQ_DEPTH];
  logic [31:0]   inst_id_q, inst_id_d;
  logic [31:0]   pc_id_q, pc_id_d;
  logic          inst_valid_id_q, inst_valid_id_d;
  logic          fetch_misalign_q, fetch_misalign_d;

  logic start_sel, redirect, flush, credit_ok, accept;
  logic rsp_drop, rsp_keep, pop_ok, fq_empty, fq_full, bypass, fq_pop, fq_push;
  logic [31:0] rsp_pc;
  logic unused_alu_bit;

  assign unused_alu_bit = alu_out[0];

  assign start_sel = (pc_sel == PC_SEL_START_ADDR);
  assign redirect  = pc_we && (pc_sel == PC_SEL_ALU);
  assign flush     = start_sel || redirect;
  assign credit_ok = ({1'b0, fq_cnt_q} + {1'b0, outst_q}) < {1'b0, DEPTH_C};
  assign imem_req  = rst && credit_ok && !flush;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // Responses are in order: the first drop_cnt of them belong to flushed requests.
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !flush;
  assign rsp_pc   = pcf_q[pcf_rd_q];
  assign pop_ok   = !flush && !clear_id && !stall_if;
  assign fq_empty = (fq_cnt_q == '0);
  assign fq_full  = (fq_cnt_q == DEPTH_C);
  assign bypass   = rsp_keep && fq_empty && pop_ok;
  assign fq_pop   = pop_ok && !fq_empty;
  assign fq_push  = rsp_keep && !bypass;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (start_sel) begin
      fetch_pc_d = RESET_VECTOR;
    end else if (redirect) begin
      fetch_pc_d = {alu_out[31:2], 2'b00};
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    fetch_misalign_d = redirect && alu_out[1];
  end

  always_comb begin
    outst_d = outst_q;
    if (accept) begin
      outst_d = outst_d + CW'(1);
    end
    if (imem_rsp_valid) begin
      outst_d = outst_d - CW'(1);
    end
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = imem_rsp_valid ? outst_q - CW'(1) : outst_q;
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Request-PC FIFO: flushed requests never pop it, so a flush simply empties it.
  always_comb begin
    pcf_d    = pcf_q;
    pcf_rd_d = pcf_rd_q;
    pcf_wr_d = pcf_wr_q;
    if (flush) begin
      pcf_rd_d = '0;
      pcf_wr_d = '0;
    end else begin
      if (accept) begin
        pcf_d[pcf_wr_q] = fetch_pc_q;
        pcf_wr_d        = ptr_inc(pcf_wr_q);
      end
      if (rsp_keep) begin
        pcf_rd_d = ptr_inc(pcf_rd_q);
      end
    end
  end

  always_comb begin
    fq_inst_d = fq_inst_q;
    fq_pc_d   = fq_pc_q;
    fq_rd_d   = fq_rd_q;
    fq_wr_d   = fq_wr_q;
    fq_cnt_d  = fq_cnt_q;
    if (flush) begin
      fq_rd_d  = '0;
      fq_wr_d  = '0;
      fq_cnt_d = '0;
    end else begin
      if (fq_push) begin
        fq_inst_d[fq_wr_q] = imem_rsp_data;
        fq_pc_d[fq_wr_q]   = rsp_pc;
        fq_wr_d            = ptr_inc(fq_wr_q);
      end
      if (fq_pop) begin
        fq_rd_d = ptr_inc(fq_rd_q);
      end
      case ({fq_push, fq_pop})
        2'b10:   fq_cnt_d = fq_cnt_q + CW'(1);
        2'b01:   fq_cnt_d = fq_cnt_q - CW'(1);
        default: fq_cnt_d = fq_cnt_q;
      endcase
    end
  end

  always_comb begin
    inst_id_d       = NOP_INST;
    pc_id_d         = pc_id_q;
    inst_valid_id_d = 1'b0;
    if (fq_pop) begin
      inst_id_d       = fq_inst_q[fq_rd_q];
      pc_id_d         = fq_pc_q[fq_rd_q];
      inst_valid_id_d = 1'b1;
    end else if (bypass) begin
      inst_id_d       = imem_rsp_data;
      pc_id_d         = rsp_pc;
      inst_valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q       <= RESET_VECTOR;
      outst_q          <= '0;
      drop_cnt_q       <= '0;
      fq_cnt_q         <= '0;
      fq_rd_q          <= '0;
      fq_wr_q          <= '0;
      pcf_rd_q         <= '0;
      pcf_wr_q         <= '0;
      inst_id_q        <= NOP_INST;
      pc_id_q          <= RESET_VECTOR;
      inst_valid_id_q  <= 1'b0;
      fetch_misalign_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      outst_q          <= outst_d;
      drop_cnt_q       <= drop_cnt_d;
      fq_cnt_q         <= fq_cnt_d;
      fq_rd_q          <= fq_rd_d;
      fq_wr_q          <= fq_wr_d;
      pcf_rd_q         <= pcf_rd_d;
      pcf_wr_q         <= pcf_wr_d;
      inst_id_q        <= inst_id_d;
      pc_id_q          <= pc_id_d;
      inst_valid_id_q  <= inst_valid_id_d;
      fetch_misalign_q <= fetch_misalign_d;
    end
  end

  // Payload storage is qualified by the pointers/counts, so it needs no reset.
  always_ff @(posedge clk) begin
    fq_inst_q <= fq_inst_d;
    fq_pc_q   <= fq_pc_d;
    pcf_q     <= pcf_d;
  end

  assign inst_id        = inst_id_q;
  assign pc_id          = pc_id_q;
  assign inst_valid_id  = inst_valid_id_q;
  assign fetch_misalign = fetch_misalign_q;

  assert property (@(posedge clk) disable iff (!rst) !(fq_push && fq_full && !fq_pop));
  assert property (@(posedge clk) disable iff (!rst) (outst_q <= DEPTH_C) && (drop_cnt_q <= outst_q));

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: directed per-cycle vector table plus randomized
// traffic, all checked against a queue-based reference model and an IMEM model.
module tb_ama_riscv_fetch;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam int unsigned DEPTH = 2;
  localparam logic [1:0]  ST = 2'd0, INC = 2'd1, ALU = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        pc_we, stall_if, clear_id;
  logic [31:0] alu_out;
  logic        imem_req, imem_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic [31:0] inst_id, pc_id;
  logic        inst_valid_id, fetch_misalign;

  always #5 clk = ~clk;

  ama_riscv_fetch #(.RESET_VECTOR(32'h0), .FQ_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we), .stall_if(stall_if),
    .clear_id(clear_id), .alu_out(alu_out), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_id(inst_id), .pc_id(pc_id), .inst_valid_id(inst_valid_id),
    .fetch_misalign(fetch_misalign)
  );

  typedef struct {
    bit rstn; bit rdy; logic [1:0] sel; bit we; bit stall; bit clr; logic [31:0] alu;
    int unsigned lat; bit chk;
    bit e_req; logic [31:0] e_addr; bit e_vld; logic [31:0] e_inst; logic [31:0] e_pc; bit e_mis;
  } vec_t;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; bit drop; } infl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  vec_t        vecs[$];
  pend_t       imem_q[$];
  infl_t       m_infl[$];
  ent_t        m_q[$];
  logic [31:0] m_pc, m_inst, m_pcid;
  bit          m_vld, m_mis;
  int          nvec = 0, nmis = 0;
  int unsigned cyc = 0, last_due = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void tv(bit rstn, bit rdy, logic [1:0] sel, bit we, bit stall, bit clr,
                             logic [31:0] alu, int unsigned lat, bit e_req, logic [31:0] e_addr,
                             bit e_vld, logic [31:0] e_inst, logic [31:0] e_pc, bit e_mis);
    vec_t v;
    v = '{rstn: rstn, rdy: rdy, sel: sel, we: we, stall: stall, clr: clr, alu: alu, lat: lat,
          chk: 1'b1, e_req: e_req, e_addr: e_addr, e_vld: e_vld, e_inst: e_inst, e_pc: e_pc,
          e_mis: e_mis};
    vecs.push_back(v);
  endfunction

  function automatic void tv_rst(int unsigned lat);
    for (int i = 0; i < 2; i++) tv(0, 1, INC, 0, 0, 0, 0, lat, 0, 32'h0, 0, NOP, 32'h0, 0);
  endfunction

  // Reference model: requests in flight are a queue of PCs tagged 'drop' once flushed.
  task automatic model_step(input vec_t v, input bit rspv, output bit e_req, output logic [31:0] e_addr);
    bit start, redir, flush, keep;
    ent_t kept, head;
    infl_t f;
    keep = 0;
    kept = '{inst: 32'h0, pc: 32'h0};
    if (!v.rstn) begin
      m_q.delete(); m_infl.delete();
      m_pc = 32'h0; m_inst = NOP; m_pcid = 32'h0; m_vld = 0; m_mis = 0;
      e_req = 0; e_addr = m_pc;
      return;
    end
    start  = (v.sel == ST);
    redir  = v.we && (v.sel == ALU);
    flush  = start || redir;
    e_addr = m_pc;
    e_req  = ((m_q.size() + m_infl.size()) < DEPTH) && !flush;
    if (rspv && m_infl.size() > 0) begin
      f = m_infl.pop_front();
      if (!f.drop && !flush) begin
        keep = 1; kept.pc = f.pc; kept.inst = f.pc ^ KEY;
      end
    end
    if (flush) begin
      foreach (m_infl[i]) m_infl[i].drop = 1;
      m_q.delete();
    end
    if (e_req && v.rdy) begin
      f.pc = m_pc; f.drop = 0;
      m_infl.push_back(f);
      m_pc = m_pc + 32'd4;
    end
    if (start) m_pc = 32'h0;
    else if (redir) m_pc = {v.alu[31:2], 2'b00};
    m_mis  = redir && v.alu[1];
    m_vld  = 0;
    m_inst = NOP;
    if (!(v.clr || flush || v.stall)) begin
      if (m_q.size() > 0) begin
        head = m_q.pop_front();
        m_inst = head.inst; m_pcid = head.pc; m_vld = 1;
      end else if (keep) begin
        m_inst = kept.inst; m_pcid = kept.pc; m_vld = 1; keep = 0;
      end
    end
    if (keep) m_q.push_back(kept);
  endtask

  task automatic run_cycle(input vec_t v);
    bit e_req, rspv;
    logic [31:0] e_addr;
    pend_t p;
    @(negedge clk);
    rst = v.rstn; imem_ready = v.rdy; pc_sel = v.sel; pc_we = v.we;
    stall_if = v.stall; clear_id = v.clr; alu_out = v.alu;
    rspv = 0;
    if (!v.rstn) begin
      imem_q.delete();
      last_due = 0;
    end else if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      p = imem_q.pop_front();
      rspv = 1;
      imem_rsp_data = p.addr ^ KEY;
    end
    if (!rspv) imem_rsp_data = $urandom;
    imem_rsp_valid = rspv;
    #1;
    model_step(v, rspv, e_req, e_addr);
    check("imem_req", 32'(imem_req), 32'(e_req));
    check("imem_addr", imem_addr, e_addr);
    if (v.chk) begin
      check("tbl_imem_req", 32'(imem_req), 32'(v.e_req));
      check("tbl_imem_addr", imem_addr, v.e_addr);
    end
    if (v.rstn && imem_req && imem_ready) begin
      p.addr = imem_addr;
      p.due  = (cyc + v.lat > last_due) ? cyc + v.lat : last_due;
      last_due = p.due;
      imem_q.push_back(p);
    end
    @(posedge clk);
    #1;
    check("inst_id", inst_id, m_inst);
    check("pc_id", pc_id, m_pcid);
    check("inst_valid_id", 32'(inst_valid_id), 32'(m_vld));
    check("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    if (v.chk) begin
      check("tbl_inst_id", inst_id, v.e_inst);
      check("tbl_pc_id", pc_id, v.e_pc);
      check("tbl_valid", 32'(inst_valid_id), 32'(v.e_vld));
      check("tbl_misalign", 32'(fetch_misalign), 32'(v.e_mis));
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int unsigned r;
    rst = 0; pc_sel = INC; pc_we = 0; stall_if = 0; clear_id = 0; alu_out = 0;
    imem_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;

    // Streaming from reset, then a 5-cycle ready stall at 0x10.
    tv_rst(1);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h00, 0, NOP,          32'h00, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h04, 1, 32'hA5A50000, 32'h00, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h08, 1, 32'hA5A50004, 32'h04, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h0C, 1, 32'hA5A50008, 32'h08, 0);
    tv(1, 0, INC, 0, 0, 0, 0, 1, 1, 32'h10, 1, 32'hA5A5000C, 32'h0C, 0);
    for (int i = 0; i < 4; i++) tv(1, 0, INC, 0, 0, 0, 0, 1, 1, 32'h10, 0, NOP, 32'h0C, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h10, 0, NOP,          32'h0C, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h14, 1, 32'hA5A50010, 32'h10, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h18, 1, 32'hA5A50014, 32'h14, 0);
    // Two-cycle stall_if with words 0x8 and 0xC queued.
    tv_rst(1);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h00, 0, NOP,          32'h00, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h04, 1, 32'hA5A50000, 32'h00, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h08, 1, 32'hA5A50004, 32'h04, 0);
    tv(1, 1, INC, 0, 1, 0, 0, 1, 1, 32'h0C, 0, NOP,          32'h04, 0);
    tv(1, 1, INC, 0, 1, 0, 0, 1, 0, 32'h10, 0, NOP,          32'h04, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 0, 32'h10, 1, 32'hA5A50008, 32'h08, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h10, 1, 32'hA5A5000C, 32'h0C, 0);
    tv(1, 1, INC, 0, 0, 0, 0, 1, 1, 32'h14, 1, 32'hA5A50010, 32'h10, 0);
    // Redirect to 0x200 with two requests outstanding, then misaligned redirect 0x102.
    tv_rst(3);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h000, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h004, 0, NOP,          32'h000, 0);
    tv(1, 1, ALU, 1, 0, 0, 32'h200,    3, 0, 32'h008, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 0, 32'h200, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h200, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h204, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 0, 32'h208, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 0, 32'h208, 1, 32'hA5A50200, 32'h200, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h208, 1, 32'hA5A50204, 32'h204, 0);
    tv(1, 1, ALU, 1, 0, 0, 32'h102,    3, 0, 32'h20C, 0, NOP,          32'h204, 1);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 1, 32'h100, 0, NOP,          32'h204, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          3, 0, 32'h104, 0, NOP,          32'h204, 0);
    // Redirect coincident with a response and clear_id, later a START select.
    tv_rst(2);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h000, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h004, 0, NOP,          32'h000, 0);
    tv(1, 1, ALU, 1, 0, 1, 32'h300,    2, 0, 32'h008, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h300, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h304, 0, NOP,          32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 0, 32'h308, 1, 32'hA5A50300, 32'h300, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h308, 1, 32'hA5A50304, 32'h304, 0);
    tv(1, 1, ST,  0, 0, 0, 0,          2, 0, 32'h30C, 0, NOP,          32'h304, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h000, 0, NOP,          32'h304, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h004, 0, NOP,          32'h304, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 0, 32'h008, 1, 32'hA5A50000, 32'h000, 0);
    tv(1, 1, INC, 0, 0, 0, 0,          2, 1, 32'h008, 1, 32'hA5A50004, 32'h004, 0);

    foreach (vecs[i]) run_cycle(vecs[i]);

    // Randomized traffic: checked against the reference model only.
    for (int i = 0; i < 3000; i++) begin
      rv = '{rstn: 1'b1, rdy: 1'b1, sel: INC, we: 1'b0, stall: 1'b0, clr: 1'b0, alu: 32'h0,
             lat: 1, chk: 1'b0, e_req: 1'b0, e_addr: 32'h0, e_vld: 1'b0, e_inst: 32'h0,
             e_pc: 32'h0, e_mis: 1'b0};
      rv.rstn  = ($urandom_range(0, 199) != 0);
      rv.rdy   = ($urandom_range(0, 99) < 70);
      rv.stall = ($urandom_range(0, 99) < 15);
      rv.clr   = ($urandom_range(0, 99) < 5);
      rv.lat   = $urandom_range(1, 3);
      rv.alu   = $urandom;
      rv.we    = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 3)       rv.sel = ST;
      else if (r < 13) rv.sel = ALU;
      else if (r < 16) rv.sel = 2'd3;
      else             rv.sel = INC;
      run_cycle(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
